// File: rtl/temporal_clause_buffer_bank_if.sv
// Write/select/stream bundle for temporal_clause_buffer_bank; slave = buffer, master = pipeline driver.
// The out channel stalls on out_ready_i; write/select handshakes are accepted only while the buffer is idle.
interface temporal_clause_buffer_bank_if #(
  parameter int NSAT                     = 3,
  parameter int LITERAL_ADDRESS_WIDTH    = 11,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NUM_CANDIDATES           = 4,
  parameter int CAND_BITS                = 2,
  parameter int CLAUSE_CNT_BITS          = 5
) ();
  localparam int L1 = LITERAL_ADDRESS_WIDTH + 1;
  localparam int CW = MAX_CLAUSES_PER_VARIABLE * (NSAT - 1) * L1;

  logic                       clear_i;
  logic                       wr_valid_i;
  logic                       wr_ready_o;
  logic [CAND_BITS-1:0]       wr_index_i;
  logic [L1-1:0]              wr_flipped_literal_i;
  logic [CW-1:0]              wr_clause_literals_i;
  logic [CLAUSE_CNT_BITS-1:0] wr_clause_count_i;
  logic                       sel_valid_i;
  logic                       sel_ready_o;
  logic [CAND_BITS-1:0]       sel_index_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [NSAT*L1-1:0]         out_clause_o;
  logic [CLAUSE_CNT_BITS-1:0] out_clause_idx_o;
  logic                       out_last_o;
  logic                       done_o;
  logic                       sel_err_o;
  logic [NUM_CANDIDATES-1:0]  cand_valid_o;

  modport slave (
    input  clear_i, wr_valid_i, wr_index_i, wr_flipped_literal_i, wr_clause_literals_i,
           wr_clause_count_i, sel_valid_i, sel_index_i, out_ready_i,
    output wr_ready_o, sel_ready_o, out_valid_o, out_clause_o, out_clause_idx_o,
           out_last_o, done_o, sel_err_o, cand_valid_o
  );

  modport master (
    output clear_i, wr_valid_i, wr_index_i, wr_flipped_literal_i, wr_clause_literals_i,
           wr_clause_count_i, sel_valid_i, sel_index_i, out_ready_i,
    input  wr_ready_o, sel_ready_o, out_valid_o, out_clause_o, out_clause_idx_o,
           out_last_o, done_o, sel_err_o, cand_valid_o
  );
endinterface

// File: rtl/temporal_clause_buffer_bank.sv
// Stages clause sets for NUM_CANDIDATES flips and streams the selected one, one clause/cycle from the cycle after select; out_ready_i stalls hold the clause.
// Optional macro TEMPORAL_CLAUSE_BUFFER_RETAIN_EN keeps candidate valid bits after a completed stream.
module temporal_clause_buffer_bank #(
  parameter int NSAT                     = 3,
  parameter int LITERAL_ADDRESS_WIDTH    = 11,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NUM_CANDIDATES           = 4,
  parameter int CAND_BITS                = 2,
  parameter int CLAUSE_CNT_BITS          = 5
) (
  input logic                        clk,
  input logic                        reset,
  temporal_clause_buffer_bank_if.slave bus
);
  localparam int L1   = LITERAL_ADDRESS_WIDTH + 1;
  localparam int MAXC = MAX_CLAUSES_PER_VARIABLE;
  localparam int RW   = (NSAT - 1) * L1;
  localparam int CW   = MAXC * RW;
  localparam logic [CLAUSE_CNT_BITS-1:0] MAXC_C = CLAUSE_CNT_BITS'(MAXC);
  localparam logic [CLAUSE_CNT_BITS-1:0] ONE_C  = CLAUSE_CNT_BITS'(1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                     state_q;
  logic [NUM_CANDIDATES-1:0]  cand_valid_q;
  logic [CLAUSE_CNT_BITS-1:0] counter_q;
  logic [CAND_BITS-1:0]       sel_q;
  logic                       done_q;
  logic                       sel_err_q;

  logic [L1-1:0]              lit_q [NUM_CANDIDATES];
  logic [CW-1:0]              cls_q [NUM_CANDIDATES];
  logic [CLAUSE_CNT_BITS-1:0] cnt_q [NUM_CANDIDATES];

  logic                       streaming;
  logic                       wr_rdy;
  logic                       wr_fire;
  logic                       sel_fire;
  logic                       wr_in_range;
  logic                       sel_in_range;
  logic                       last;
  logic [CLAUSE_CNT_BITS-1:0] wr_cnt_sat;
  logic [RW-1:0]              slot_rest;

  assign streaming    = (state_q == STREAM);
  assign wr_rdy       = ~streaming & ~reset & ~bus.clear_i;
  assign wr_fire      = wr_rdy & bus.wr_valid_i;
  assign sel_fire     = wr_rdy & ~bus.wr_valid_i & bus.sel_valid_i;
  assign wr_in_range  = int'(bus.wr_index_i) < NUM_CANDIDATES;
  assign sel_in_range = int'(bus.sel_index_i) < NUM_CANDIDATES;
  assign wr_cnt_sat   = (bus.wr_clause_count_i > MAXC_C) ? MAXC_C : bus.wr_clause_count_i;
  // A streamed entry always has count >= 1, so count-1 cannot wrap here.
  assign last         = (counter_q == cnt_q[sel_q] - ONE_C);
  assign slot_rest    = cls_q[sel_q][int'(counter_q)*RW +: RW];

  assign bus.wr_ready_o       = wr_rdy;
  assign bus.sel_ready_o      = wr_rdy & ~bus.wr_valid_i;
  assign bus.out_valid_o      = streaming;
  assign bus.out_last_o       = streaming & last;
  assign bus.out_clause_idx_o = streaming ? counter_q : '0;
  assign bus.out_clause_o     = streaming ? {slot_rest, lit_q[sel_q]} : '0;
  assign bus.done_o           = done_q;
  assign bus.sel_err_o        = sel_err_q;
  assign bus.cand_valid_o     = cand_valid_q;

  // Storage is not reset; only valid entries are ever streamed.
  always_ff @(posedge clk) begin
    if (wr_fire && wr_in_range) begin
      lit_q[bus.wr_index_i] <= bus.wr_flipped_literal_i;
      cls_q[bus.wr_index_i] <= bus.wr_clause_literals_i;
      cnt_q[bus.wr_index_i] <= wr_cnt_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear_i) begin
      state_q      <= IDLE;
      cand_valid_q <= '0;
      counter_q    <= '0;
      sel_q        <= '0;
      done_q       <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_fire) begin
            if (wr_in_range) cand_valid_q[bus.wr_index_i] <= 1'b1;
          end else if (sel_fire) begin
            if (sel_in_range && cand_valid_q[bus.sel_index_i]) begin
              if (cnt_q[bus.sel_index_i] != '0) begin
                state_q   <= STREAM;
                counter_q <= '0;
                sel_q     <= bus.sel_index_i;
              end else begin
                done_q <= 1'b1;
              end
            end else begin
              sel_err_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (bus.out_ready_i) begin
            if (last) begin
              state_q   <= IDLE;
              counter_q <= '0;
              done_q    <= 1'b1;
`ifdef TEMPORAL_CLAUSE_BUFFER_RETAIN_EN
              cand_valid_q <= cand_valid_q;
`else
              cand_valid_q <= '0;
`endif
            end else begin
              counter_q <= counter_q + ONE_C;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_temporal_clause_buffer_bank.sv
// Bench for temporal_clause_buffer_bank: directed vector table, hand sequences, then randomized traffic against a transaction-level model.
module tb_temporal_clause_buffer_bank;
  localparam int NSAT = 3;
  localparam int L1   = 12;
  localparam int MAXC = 20;
  localparam int NC   = 4;
  localparam int CW   = MAXC * (NSAT - 1) * L1;
`ifdef TEMPORAL_CLAUSE_BUFFER_RETAIN_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  temporal_clause_buffer_bank_if bus ();
  temporal_clause_buffer_bank dut (.clk(clk), .reset(reset), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: entries as arrays of literals, stream as (entry, position).
  logic [L1-1:0] m_lit [NC];
  logic [L1-1:0] m_cls [NC][MAXC][NSAT-1];
  int            m_cnt [NC];
  logic [NC-1:0] m_cv;
  bit            m_str;
  int            m_sel, m_pos;
  bit            m_done, m_err;

  task automatic mcheck();
    logic [NSAT*L1-1:0] ec;
    bit exp_wr;
    ec = '0;
    if (m_str) begin
      ec[L1-1:0] = m_lit[m_sel];
      for (int j = 0; j < NSAT - 1; j++) ec[(j+1)*L1 +: L1] = m_cls[m_sel][m_pos][j];
    end
    exp_wr = !m_str && !reset && !bus.clear_i;
    chk("m_out_valid", bus.out_valid_o, m_str);
    chk("m_out_clause", bus.out_clause_o, ec);
    chk("m_out_idx", bus.out_clause_idx_o, m_str ? m_pos : 0);
    chk("m_out_last", bus.out_last_o, m_str && (m_pos == m_cnt[m_sel] - 1));
    chk("m_done", bus.done_o, m_done);
    chk("m_sel_err", bus.sel_err_o, m_err);
    chk("m_cand_valid", bus.cand_valid_o, m_cv);
    chk("m_wr_ready", bus.wr_ready_o, exp_wr);
    chk("m_sel_ready", bus.sel_ready_o, exp_wr && !bus.wr_valid_i);
  endtask

  task automatic mupdate();
    bit wr_ok;
    int wi, si;
    wr_ok = !m_str && !reset && !bus.clear_i;
    wi = int'(bus.wr_index_i);
    si = int'(bus.sel_index_i);
    if (reset || bus.clear_i) begin
      m_str = 0; m_cv = '0; m_pos = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0; m_err = 0;
      if (wr_ok && bus.wr_valid_i) begin
        if (wi < NC) begin
          m_lit[wi] = bus.wr_flipped_literal_i;
          for (int k = 0; k < MAXC; k++)
            for (int j = 0; j < NSAT - 1; j++)
              m_cls[wi][k][j] = bus.wr_clause_literals_i[(k*(NSAT-1)+j)*L1 +: L1];
          m_cnt[wi] = (int'(bus.wr_clause_count_i) > MAXC) ? MAXC : int'(bus.wr_clause_count_i);
          m_cv[wi] = 1'b1;
        end
      end else if (wr_ok && bus.sel_valid_i) begin
        if (si < NC && m_cv[si]) begin
          if (m_cnt[si] > 0) begin m_str = 1; m_sel = si; m_pos = 0; end
          else m_done = 1;
        end else m_err = 1;
      end else if (m_str && bus.out_ready_i) begin
        if (m_pos == m_cnt[m_sel] - 1) begin
          m_str = 0; m_done = 1;
          if (!RET) m_cv = '0;
        end else m_pos++;
      end
    end
  endtask

  task automatic rand_data();
    bus.wr_flipped_literal_i = L1'($urandom());
    for (int i = 0; i < CW / 32; i++) bus.wr_clause_literals_i[i*32 +: 32] = $urandom();
  endtask

  task automatic half();
    @(negedge clk);
    mcheck();
  endtask

  task automatic adv();
    mupdate();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wv, input int wi, input int wc, input bit sv, input int si,
                       input bit rdy, input bit clr, input bit rst);
    bus.wr_valid_i = wv; bus.wr_index_i = 2'(wi); bus.wr_clause_count_i = 5'(wc);
    bus.sel_valid_i = sv; bus.sel_index_i = 2'(si);
    bus.out_ready_i = rdy; bus.clear_i = clr; reset = rst;
    rand_data();
  endtask

  typedef struct {
    bit wv; int wi; int wc; bit sv; int si; bit rdy; bit clr; bit rst;
    bit e_ov; int e_idx; bit e_last; bit e_done; bit e_err;
    logic [3:0] e_cv; logic [3:0] e_cvr; bit e_wr; bit e_sr;
  } vec_t;

  function automatic vec_t mk(bit wv, int wi, int wc, bit sv, int si, bit rdy, bit clr, bit rst,
                              bit ov, int idx, bit last, bit done, bit err,
                              logic [3:0] cv, logic [3:0] cvr, bit wr, bit sr);
    vec_t v;
    v = '{wv, wi, wc, sv, si, rdy, clr, rst, ov, idx, last, done, err, cv, cvr, wr, sr};
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    m_cv = '0; m_str = 0; m_sel = 0; m_pos = 0; m_done = 0; m_err = 0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    //        wv wi wc sv si rdy clr rst | ov idx last done err  cv       cv(retain) wr sr
    tbl.push_back(mk(1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b0010, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0010, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0010, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 1, 0, 0, 4'b0010, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0010, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0010, 1, 1));
    tbl.push_back(mk(1, 3, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 4'b1010, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4'b1000, 4'b1010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b1000, 4'b1010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b1000, 4'b1010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b1000, 4'b1010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 4'b1000, 4'b1010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 1, 0, 0, 4'b1000, 4'b1010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b1010, 1, 1));
    tbl.push_back(mk(1, 2, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1010, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 4'b1110, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0100, 4'b1110, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 4'b0100, 4'b1110, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b1110, 1, 1));
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1110, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b1110, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0010, 4'b1110, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 4'b0010, 4'b1110, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mk(1, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b0010, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0010, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 4'b0010, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].wv, tbl[i].wi, tbl[i].wc, tbl[i].sv, tbl[i].si, tbl[i].rdy, tbl[i].clr, tbl[i].rst);
      half();
      chk($sformatf("t%0d_out_valid", i), bus.out_valid_o, tbl[i].e_ov);
      chk($sformatf("t%0d_out_idx", i), bus.out_clause_idx_o, tbl[i].e_idx);
      chk($sformatf("t%0d_out_last", i), bus.out_last_o, tbl[i].e_last);
      chk($sformatf("t%0d_done", i), bus.done_o, tbl[i].e_done);
      chk($sformatf("t%0d_sel_err", i), bus.sel_err_o, tbl[i].e_err);
      chk($sformatf("t%0d_cand_valid", i), bus.cand_valid_o, RET ? tbl[i].e_cvr : tbl[i].e_cv);
      chk($sformatf("t%0d_wr_ready", i), bus.wr_ready_o, tbl[i].e_wr);
      chk($sformatf("t%0d_sel_ready", i), bus.sel_ready_o, tbl[i].e_sr);
      adv();
    end

    // Count 25 saturates to a 20-clause stream.
    drive(1, 0, 25, 0, 0, 1, 0, 0); half(); adv();
    drive(0, 0, 0, 1, 0, 1, 0, 0); half(); adv();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < MAXC; k++) begin
      half();
      chk($sformatf("sat_valid_%0d", k), bus.out_valid_o, 1);
      chk($sformatf("sat_idx_%0d", k), bus.out_clause_idx_o, k);
      chk($sformatf("sat_last_%0d", k), bus.out_last_o, k == MAXC - 1);
      adv();
    end
    half();
    chk("sat_done", bus.done_o, 1);
    chk("sat_end_valid", bus.out_valid_o, 0);
    adv();

    // Zero-count entry: select completes immediately with done, no stream.
    drive(1, 1, 0, 0, 0, 1, 0, 0); half(); adv();
    drive(0, 0, 0, 1, 1, 1, 0, 0); half(); adv();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    half();
    chk("zero_done", bus.done_o, 1);
    chk("zero_valid", bus.out_valid_o, 0);
    chk("zero_err", bus.sel_err_o, 0);
    adv();

    for (int c = 0; c < 3000; c++) begin
      drive(($urandom() % 3) == 0, $urandom_range(0, 3), $urandom_range(0, 25),
            ($urandom() % 3) == 0, $urandom_range(0, 3), ($urandom() % 4) != 0,
            ($urandom() % 80) == 0, ($urandom() % 200) == 0);
      half();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/temporal_clause_buffer_bank.md
# temporal_clause_buffer_bank

Multi-candidate clause staging buffer for the WalkSAT flip pipeline. It captures the rebuilt clause sets of up to NUM_CANDIDATES candidate flips, one write per candidate. When the heuristic selector picks a winner, it streams that candidate's clauses out one clause per cycle under a valid/ready handshake. It sits between clause-table readout and the clause re-evaluation/break-count stage, and generalises the per-variable temporal buffer array with independent candidate depth, per-candidate clause counts, validity tracking and backpressured output.

## Interface
- NSAT, 3, literals per clause
- LITERAL_ADDRESS_WIDTH, 11, literal is LITERAL_ADDRESS_WIDTH+1 bits (L1 below)
- MAX_CLAUSES_PER_VARIABLE, 20, clause slots per candidate (MAXC)
- NUM_CANDIDATES, 4, candidate entries
- CAND_BITS, 2, index width, ≥ clog2(NUM_CANDIDATES)
- CLAUSE_CNT_BITS, 5, count width, ≥ clog2(MAXC+1)

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- clear_i  in  1  drop all candidates and abort any stream
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted when wr_valid_i & wr_ready_o
- wr_index_i  in  CAND_BITS  target candidate
- wr_flipped_literal_i  in  L1  flipped literal, common to all clauses
- wr_clause_literals_i  in  MAXC*(NSAT-1)*L1  remaining literals; clause k at slice k*(NSAT-1)*L1
- wr_clause_count_i  in  CLAUSE_CNT_BITS  number of valid clauses
- sel_valid_i  in  1  selection request
- sel_ready_o  out  1  selection accepted when sel_valid_i & sel_ready_o
- sel_index_i  in  CAND_BITS  winning candidate
- out_valid_o  out  1  clause valid
- out_ready_i  in  1  downstream ready
- out_clause_o  out  NSAT*L1  flipped literal in bits [L1-1:0], remaining literals above in input order
- out_clause_idx_o  out  CLAUSE_CNT_BITS  slot index of out_clause_o
- out_last_o  out  1  final clause of stream
- done_o  out  1  one-cycle pulse: selection fully served
- sel_err_o  out  1  one-cycle pulse: selected candidate not valid
- cand_valid_o  out  NUM_CANDIDATES  per-candidate valid bits

## Operation
- FSM states: IDLE, STREAM.
- Reset/clear register values: state IDLE; cand_valid, counter, done_o, sel_err_o all 0. Storage contents are not reset.
- wr_ready_o = (state==IDLE) & ~reset & ~clear_i.
- sel_ready_o = wr_ready_o & ~wr_valid_i. A write takes priority, and a select presented in the same cycle is deferred.
- Write behaviour:
  - Stores the literal, clauses and count into entry wr_index_i and sets its valid bit.
  - Rewriting a valid entry overwrites it.
  - wr_index_i ≥ NUM_CANDIDATES: the write is accepted and dropped, with no state change.
  - wr_clause_count_i > MAXC saturates to MAXC.
- Select, when the candidate is valid with count > 0: go to STREAM with counter=0.
- Select, when the candidate is valid with count == 0: stay IDLE and pulse done_o.
- Select, when the candidate is invalid or the index is out of range: stay IDLE and pulse sel_err_o. done_o is not pulsed.
- STREAM:
  - out_valid_o=1. out_clause_o and out_clause_idx_o reflect slot = counter of the selected entry.
  - out_last_o = (counter == count-1).
  - out_valid_o, out_clause_o and out_last_o are held stable while out_ready_i=0.
  - A transfer increments counter.
  - Transfer with out_last_o: return to IDLE, pulse done_o, clear all cand_valid bits (see Configuration).
- clear_i, in any state: at the next edge, state goes to IDLE, cand_valid goes to 0 and counter goes to 0, with no done_o. clear_i overrides a same-cycle write, select or transfer.
- reset mid-stream: same effect as clear_i.
- Outputs when not in STREAM: out_valid_o=0, out_last_o=0, out_clause_idx_o=0, out_clause_o=0.

## Timing
- Write accepted at edge N: cand_valid_o updated in cycle N+1, and the entry is selectable from cycle N+1.
- Select accepted at edge N: out_valid_o=1 in cycle N+1 with slot 0.
- Throughput is one clause per cycle with out_ready_i held high. A count-C stream occupies C cycles.
- Last transfer at edge M: done_o=1 in cycle M+1, and wr_ready_o=1 in cycle M+1.
- sel_err_o and done_o for a zero-count select assert in cycle N+1.
- All outputs are registered or decoded from registered state only, with no input-to-output combinational path except wr_ready_o/sel_ready_o (via clear_i, wr_valid_i).

## Configuration
- TEMPORAL_CLAUSE_BUFFER_RETAIN_EN.
- Undefined: completing a stream clears every cand_valid bit, so each round starts empty.
- Defined: completing a stream leaves cand_valid unchanged, and candidates may be re-selected until clear_i or an overwrite. sel_err_o, clear_i and reset behaviour are unchanged.

## Test plan
- Write idx 1 (count 3), then select 1 with out_ready_i=1 → slots 0,1,2 on consecutive cycles, out_last_o on slot 2, done_o next cycle, cand_valid_o=0000 (RETAIN_EN undefined) or 0010 (defined).
- Select idx 2 while never written → no stream, sel_err_o pulse one cycle after the select.
- Count 25 with default parameters → saturates to 20: 20 clauses streamed, out_clause_idx_o 0..19.
- out_ready_i toggled 1,0,0,1 during stream → clause held stable during stalls, no slot skipped or repeated.
- wr_valid_i and sel_valid_i both high in IDLE → write lands, sel_ready_o=0 that cycle, select accepted the next cycle and streams the new data.
- clear_i asserted on the second clause of a count-5 stream → out_valid_o=0 next cycle, cand_valid_o=0, no done_o. The same check is repeated with reset.
